// File: rtl/melody_player.sv
// Song sequencer for the buzzer tone generator: walks {dur, tone} entries from a
// synchronous song ROM and plays each note with a short silent tail.
module melody_player #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 1500000,
  parameter int GAP_CYC  = 120000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic              en_o,
  output logic [4:0]        tone_o,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TICK_DIV - GAP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              en_q;
  logic [4:0]        tone_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        unit_q;
  logic [CNT_W-1:0]  cyc_q;

  logic [3:0]        rom_dur_s;
  logic [4:0]        rom_tone_s;
  logic              is_skip_s;
  logic              addr_last_s;
  logic              at_end_s;
  logic              restart_s;

  // Entry decode; a zero-length entry at the last address ends the song like a marker.
  always_comb begin
    rom_dur_s   = rom_data[8:5];
    rom_tone_s  = rom_data[4:0];
    is_skip_s   = (rom_dur_s == 4'd0) && (rom_tone_s != 5'd0);
    addr_last_s = &rom_addr_q;
    at_end_s    = ((rom_dur_s == 4'd0) && (rom_tone_s == 5'd0)) || (is_skip_s && addr_last_s);
    restart_s   = loop && (rom_addr_q != '0);
    rom_addr_d  = rom_addr_q + ADDR_W'(1);
  end

  // Sequencer FSM with registered outputs; PLAY counts whole units, the last one short by the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      en_q       <= 1'b0;
      tone_q     <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unit_q     <= 4'd0;
      cyc_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
              rom_addr_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
          S_FETCH: begin
            state_q <= S_DECODE;
          end
          S_DECODE: begin
            if (at_end_s) begin
              if (restart_s) begin
                rom_addr_q <= '0;
                state_q    <= S_FETCH;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else if (is_skip_s) begin
              rom_addr_q <= rom_addr_d;
              state_q    <= S_FETCH;
            end else begin
              tone_q  <= rom_tone_s;
              en_q    <= (rom_tone_s != 5'd0);
              unit_q  <= rom_dur_s;
              cyc_q   <= '0;
              state_q <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (unit_q > 4'd1) begin
              if (cyc_q == UNIT_LAST) begin
                cyc_q  <= '0;
                unit_q <= unit_q - 4'd1;
              end else begin
                cyc_q <= cyc_q + CNT_W'(1);
              end
            end else if (cyc_q == TAIL_LAST) begin
              cyc_q   <= '0;
              en_q    <= 1'b0;
              state_q <= S_GAP;
            end else begin
              cyc_q <= cyc_q + CNT_W'(1);
            end
          end
          S_GAP: begin
            if (cyc_q == GAP_LAST) begin
              cyc_q <= '0;
              if (addr_last_s) begin
                if (restart_s) begin
                  rom_addr_q <= '0;
                  state_q    <= S_FETCH;
                end else begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
                end
              end else begin
                rom_addr_q <= rom_addr_d;
                state_q    <= S_FETCH;
              end
            end else begin
              cyc_q <= cyc_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_addr = rom_addr_q;
  assign en_o     = en_q;
  assign tone_o   = tone_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: a timeline model of the song rules predicts note and
// done events; a negedge monitor reconstructs them from the DUT and scores them.
module tb_melody_player;

  localparam int T   = 10;
  localparam int G   = 2;
  localparam int AW  = 4;
  localparam int BIG = 32'h3fff_ffff;

  typedef struct {
    int kind;   // 0 = note, 1 = done
    int t;      // absolute edge at which the event becomes visible
    int tone;
    int len;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic          start_s;
  logic          stop_s;
  logic          loop_s;
  logic [AW-1:0] rom_addr_s;
  logic [8:0]    rom_data_r;
  logic          en_s;
  logic [4:0]    tone_s;
  logic          busy_s;
  logic          done_s;

  logic [8:0]    rom [16];
  ev_t           exp_q[$];
  int            cyc;
  int            checks;
  int            errors;

  melody_player #(.ADDR_W(AW), .TICK_DIV(T), .GAP_CYC(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .stop     (stop_s),
    .loop     (loop_s),
    .rom_addr (rom_addr_s),
    .rom_data (rom_data_r),
    .en_o     (en_s),
    .tone_o   (tone_s),
    .busy     (busy_s),
    .done     (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data_r <= rom[rom_addr_s];

  function automatic ev_t mk_ev(input int kind, input int t, input int tone, input int len);
    ev_t e;
    e.kind = kind; e.t = t; e.tone = tone; e.len = len;
    return e;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic sb_compare(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d t=%0d tone=%0d len=%0d, required no event",
               got.kind, got.t, got.tone, got.len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != got.kind || e.t != got.t || e.tone != got.tone || e.len != got.len) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d t=%0d tone=%0d len=%0d, required kind=%0d t=%0d tone=%0d len=%0d",
                 got.kind, got.t, got.tone, got.len, e.kind, e.t, e.tone, e.len);
      end
    end
  endtask

  // Song timeline: each slot is FETCH+DECODE then dur*T cycles; ends, loops and a cut edge apply.
  task automatic model_run(input int s0, input bit lp0, input int clear_e, input int cut,
                           input bit drop_open, output int end_e);
    int addr, s, d, dur, tone, rise, fall, slot_end, guard;
    bit fin, at_end;
    addr = 0; s = s0; guard = 0; fin = 1'b0; end_e = s0;
    while (!fin && guard < 5000) begin
      guard++;
      dur  = int'(rom[addr][8:5]);
      tone = int'(rom[addr][4:0]);
      at_end = 1'b0;
      if (dur == 0) begin
        d = s + 2;
        if (d >= cut) begin fin = 1'b1; end_e = cut; end
        else if (tone == 0 || addr == 15) at_end = 1'b1;
        else begin addr++; s = d; end
      end else begin
        rise = s + 2;
        fall = rise + dur * T - G;
        slot_end = s + dur * T + 2;
        d = slot_end;
        if (tone != 0) begin
          if (rise >= cut) begin fin = 1'b1; end_e = cut; end
          else if (fall >= cut) begin
            if (!drop_open) exp_q.push_back(mk_ev(0, rise, tone, cut - rise));
            fin = 1'b1; end_e = cut;
          end else exp_q.push_back(mk_ev(0, rise, tone, fall - rise));
        end
        if (!fin) begin
          if (slot_end >= cut) begin fin = 1'b1; end_e = cut; end
          else if (addr == 15) at_end = 1'b1;
          else begin addr++; s = slot_end; end
        end
      end
      if (at_end) begin
        if (lp0 && d < clear_e && addr != 0) begin addr = 0; s = d; end
        else begin exp_q.push_back(mk_ev(1, d, 0, 0)); end_e = d; fin = 1'b1; end
      end
    end
  endtask

  // Called at a negedge; start is sampled on the next posedge.
  task automatic play(input bit lp0, input int clear_rel, input int stop_rel, input bit restart);
    int s0, clear_e, cut, end_e, end2, done_e;
    s0      = cyc + 1;
    clear_e = (clear_rel > 0) ? s0 + clear_rel : BIG;
    cut     = (stop_rel >= 0) ? s0 + stop_rel : BIG;
    model_run(s0, lp0, clear_e, cut, 1'b0, end_e);
    done_e = end_e;
    if (restart) begin
      model_run(done_e + 1, lp0, BIG, BIG, 1'b0, end2);
      end_e = end2;
    end
    while (cyc < end_e + 3) begin
      start_s = (cyc + 1 == s0) || (restart && (cyc + 1 == done_e || cyc + 1 == done_e + 1));
      stop_s  = (cyc + 1 == cut);
      loop_s  = lp0 && (cyc + 1 < clear_e);
      @(negedge clk);
      if (cyc == cut) begin
        check("stop_busy", int'(busy_s), 0);
        check("stop_en", int'(en_s), 0);
      end
    end
    start_s = 1'b0;
    stop_s  = 1'b0;
    check("run_end_busy", int'(busy_s), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: turns en_o high stretches into note events and done pulses into done events.
  initial begin : monitor
    bit in_note;
    int rise_c, rise_tone;
    in_note = 1'b0; rise_c = 0; rise_tone = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_note = 1'b0;
      else begin
        if (en_s && !in_note) begin
          in_note = 1'b1; rise_c = cyc; rise_tone = int'(tone_s);
        end else if (!en_s && in_note) begin
          in_note = 1'b0;
          sb_compare(mk_ev(0, rise_c, rise_tone, cyc - rise_c));
        end
        if (done_s) begin
          sb_compare(mk_ev(1, cyc, 0, 0));
          check("done_busy_low", int'(busy_s), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic load_song1();
    for (int i = 0; i < 16; i++) rom[i] = 9'd0;
    rom[0] = {4'd1, 5'd8};
    rom[1] = {4'd2, 5'd10};
  endtask

  initial begin : stim
    int s0, end_e, idle_bad, r, lp, sr, cr;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; start_s = 1'b0; stop_s = 1'b0; loop_s = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 9'd0;
    repeat (3) @(negedge clk);
    check("rst_en", int'(en_s), 0);
    check("rst_tone", int'(tone_s), 0);
    check("rst_addr", int'(rom_addr_s), 0);
    check("rst_busy", int'(busy_s), 0);
    check("rst_done", int'(done_s), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two notes, no loop
    load_song1();
    play(1'b0, 0, -1, 1'b0);
    // 2: rest then note
    for (int i = 0; i < 16; i++) rom[i] = 9'd0;
    rom[0] = {4'd1, 5'd0};
    rom[1] = {4'd1, 5'd5};
    play(1'b0, 0, -1, 1'b0);
    // 3: loop, cleared during the second pass
    load_song1();
    play(1'b1, 50, -1, 1'b0);
    // 4: stop five cycles into the tone-10 note, then replay
    play(1'b0, 0, 19, 1'b0);
    play(1'b0, 0, -1, 1'b0);
    // 5: end marker at address 0 with loop
    for (int i = 0; i < 16; i++) rom[i] = 9'd0;
    play(1'b1, 0, -1, 1'b0);
    // 5: full ROM without end marker
    for (int i = 0; i < 16; i++) rom[i] = {4'(1 + (i % 2)), 5'(i + 1)};
    play(1'b0, 0, -1, 1'b0);
    // 5: start and stop together
    play(1'b0, 0, 0, 1'b0);
    // done and start in the same cycle, then a fresh start
    load_song1();
    play(1'b0, 0, -1, 1'b1);

    // 6: reset mid-note
    s0 = cyc + 1;
    model_run(s0, 1'b0, BIG, s0 + 17, 1'b1, end_e);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    while (cyc < s0 + 16) @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("mid_rst_en", int'(en_s), 0);
    check("mid_rst_tone", int'(tone_s), 0);
    check("mid_rst_addr", int'(rom_addr_s), 0);
    check("mid_rst_busy", int'(busy_s), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_s || en_s) idle_bad++;
    end
    check("idle_after_reset", idle_bad, 0);
    check("reset_queue_drained", exp_q.size(), 0);

    // Randomized songs, loop and stop timing
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 7);
        case (r)
          0: rom[i] = 9'd0;
          1: rom[i] = {4'd0, 5'($urandom_range(1, 21))};
          2: rom[i] = {4'($urandom_range(1, 3)), 5'd0};
          default: rom[i] = {4'($urandom_range(1, 3)), 5'($urandom_range(1, 21))};
        endcase
      end
      lp = $urandom_range(0, 1);
      cr = (lp != 0 && $urandom_range(0, 1) != 0) ? $urandom_range(20, 300) : 0;
      if (lp != 0) sr = $urandom_range(5, 600);
      else sr = ($urandom_range(0, 1) != 0) ? $urandom_range(5, 400) : -1;
      play(lp[0], cr, sr, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
